sweep_stimulus_checker: RTL and testbench

Parametrised sequential successor to our exhaustive truth-table benches. It drives every input combination of an N_IN-input combinational block for a fixed dwell and compares DUT outputs against a golden model at the end of each dwell. It counts mismatches and latches the first failing vector. It sits between a DUT and a golden model inside a self-checking bench or on-board test harness.

---
 rtl/sweep_stimulus_checker.sv | 126 ++++++++++++
 tb/tb_sweep_stimulus_checker.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sweep_stimulus_checker.sv
// Sweeps every input vector of an N_IN-input combinational block, holding each for HOLD cycles,
// and compares the DUT against a golden model on the last cycle of each dwell.
module sweep_stimulus_checker #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 2,
  parameter int HOLD  = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             gray,
  input  logic             cont,
  input  logic [N_OUT-1:0] dut_out,
  input  logic [N_OUT-1:0] ref_out,
  output logic [N_IN-1:0]  vec,
  output logic             vec_valid,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N_IN:0]    err_count,
  output logic [N_IN-1:0]  first_err_vec,
  output logic             first_err_valid
);

  localparam int HCW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HCW-1:0]  HOLD_LAST  = HCW'(HOLD - 1);
  localparam logic [N_IN-1:0] INDEX_LAST = '1;
  localparam logic [N_IN:0]   ERR_MAX    = '1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]      state;
  logic [N_IN-1:0] index;
  logic [N_IN-1:0] index_inc;
  logic [HCW-1:0]  hold_cnt;
  logic            gray_q;
  logic            cont_q;
  logic            mismatch;

  function automatic logic [N_IN-1:0] map_vec(input logic [N_IN-1:0] idx, input logic use_gray);
    map_vec = use_gray ? (idx ^ (idx >> 1)) : idx;
  endfunction

  assign index_inc = index + 1'b1;
  assign mismatch  = (dut_out != ref_out);
  assign pass      = done && (err_count == '0);

  // Abort wins over everything; the compare only happens on an un-aborted last dwell cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      index           <= '0;
      hold_cnt        <= '0;
      gray_q          <= 1'b0;
      cont_q          <= 1'b0;
      vec             <= '0;
      vec_valid       <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      err_count       <= '0;
      first_err_vec   <= '0;
      first_err_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (abort) begin
            state <= S_IDLE;
            done  <= 1'b0;
          end else if (start) begin
            state           <= S_DRIVE;
            gray_q          <= gray;
            cont_q          <= cont;
            index           <= '0;
            hold_cnt        <= '0;
            vec             <= map_vec('0, gray);
            vec_valid       <= 1'b1;
            busy            <= 1'b1;
            done            <= 1'b0;
            err_count       <= '0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
          end
        end
        S_DRIVE: begin
          if (abort) begin
            state     <= S_IDLE;
            hold_cnt  <= '0;
            vec_valid <= 1'b0;
            busy      <= 1'b0;
          end else if (hold_cnt == HOLD_LAST) begin
            hold_cnt <= '0;
            if (mismatch) begin
              if (err_count != ERR_MAX)
                err_count <= err_count + 1'b1;
              if (!first_err_valid) begin
                first_err_vec   <= vec;
                first_err_valid <= 1'b1;
              end
            end
            if ((index == INDEX_LAST) && !cont_q) begin
              state     <= S_DONE;
              vec_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              index <= index_inc;
              vec   <= map_vec(index_inc, gray_q);
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          vec_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sweep_stimulus_checker.sv
// Directed bench for sweep_stimulus_checker: one HOLD=4 instance for the sweep/error cases
// and one HOLD=1 instance for the single-cycle dwell and start+abort corner.
module tb_sweep_stimulus_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       a_start, a_abort, a_gray, a_cont;
  logic [1:0] a_mode;
  logic [1:0] a_dut_out, a_ref_out;
  logic [3:0] a_vec, a_fev;
  logic [4:0] a_err;
  logic       a_vec_valid, a_busy, a_done, a_pass, a_fevalid;

  logic       b_start, b_abort;
  logic [1:0] b_dut_out;
  logic [3:0] b_vec, b_fev;
  logic [4:0] b_err;
  logic       b_vec_valid, b_busy, b_done, b_pass, b_fevalid;

  function automatic logic [1:0] dutModel(input logic [3:0] v);
    dutModel = v[1:0] ^ v[3:2];
  endfunction

  function automatic logic [3:0] expVec(input int i, input logic g);
    logic [3:0] x;
    x = i[3:0];
    expVec = g ? (x ^ (x >> 1)) : x;
  endfunction

  assign a_dut_out = dutModel(a_vec);
  assign b_dut_out = dutModel(b_vec);

  // Mode 0: golden agrees, 1: golden wrong only at vec A, 2: golden always inverted
  always_comb begin
    a_ref_out = a_dut_out;
    if (a_mode == 2'd1 && a_vec == 4'hA) a_ref_out = a_dut_out ^ 2'b01;
    else if (a_mode == 2'd2)             a_ref_out = ~a_dut_out;
  end

  sweep_stimulus_checker #(.N_IN(4), .N_OUT(2), .HOLD(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(a_start), .abort(a_abort), .gray(a_gray), .cont(a_cont),
    .dut_out(a_dut_out), .ref_out(a_ref_out), .vec(a_vec), .vec_valid(a_vec_valid),
    .busy(a_busy), .done(a_done), .pass(a_pass), .err_count(a_err),
    .first_err_vec(a_fev), .first_err_valid(a_fevalid)
  );

  sweep_stimulus_checker #(.N_IN(4), .N_OUT(2), .HOLD(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(b_start), .abort(b_abort), .gray(1'b0), .cont(1'b0),
    .dut_out(b_dut_out), .ref_out(b_dut_out), .vec(b_vec), .vec_valid(b_vec_valid),
    .busy(b_busy), .done(b_done), .pass(b_pass), .err_count(b_err),
    .first_err_vec(b_fev), .first_err_valid(b_fevalid)
  );

  typedef struct {
    logic       gray;
    logic [1:0] mode;
    logic [4:0] exp_err;
    logic [3:0] exp_fev;
    logic       exp_fevalid;
    logic       exp_pass;
  } sweep_vec_t;

  sweep_vec_t tbl[6];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic ab, input logic gr, input logic co,
                               input logic [1:0] md);
    a_start = st;
    a_abort = ab;
    a_gray  = gr;
    a_cont  = co;
    a_mode  = md;
  endtask

  task automatic runSweepA(input sweep_vec_t t, input int id);
    @(negedge clk); applyStimulus(1'b1, 1'b0, t.gray, 1'b0, t.mode);
    @(negedge clk); applyStimulus(1'b0, 1'b0, t.gray, 1'b0, t.mode);
    for (int k = 0; k < 64; k++) begin
      if (k % 4 == 1)
        checkOutput($sformatf("sweep%0d vec[%0d]", id, k / 4), a_vec, expVec(k / 4, t.gray));
      if (k == 63) begin
        checkOutput($sformatf("sweep%0d busy@63", id), a_busy, 1);
        checkOutput($sformatf("sweep%0d done@63", id), a_done, 0);
      end
      @(negedge clk);
    end
    checkOutput($sformatf("sweep%0d done", id), a_done, 1);
    checkOutput($sformatf("sweep%0d busy", id), a_busy, 0);
    checkOutput($sformatf("sweep%0d vec_valid", id), a_vec_valid, 0);
    checkOutput($sformatf("sweep%0d err_count", id), a_err, t.exp_err);
    checkOutput($sformatf("sweep%0d first_err_vec", id), a_fev, t.exp_fev);
    checkOutput($sformatf("sweep%0d first_err_valid", id), a_fevalid, t.exp_fevalid);
    checkOutput($sformatf("sweep%0d pass", id), a_pass, t.exp_pass);
  endtask

  task automatic runSweepB(input int id);
    @(negedge clk); b_start = 1'b1;
    @(negedge clk); b_start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      checkOutput($sformatf("h1 run%0d vec[%0d]", id, k), b_vec, k);
      if (k == 15) checkOutput($sformatf("h1 run%0d done@15", id), b_done, 0);
      @(negedge clk);
    end
    checkOutput($sformatf("h1 run%0d done", id), b_done, 1);
    checkOutput($sformatf("h1 run%0d pass", id), b_pass, 1);
    checkOutput($sformatf("h1 run%0d err_count", id), b_err, 0);
  endtask

  initial begin
    tbl[0] = '{gray: 1'b0, mode: 2'd0, exp_err: 5'd0,  exp_fev: 4'h0, exp_fevalid: 1'b0, exp_pass: 1'b1};
    tbl[1] = '{gray: 1'b0, mode: 2'd1, exp_err: 5'd1,  exp_fev: 4'hA, exp_fevalid: 1'b1, exp_pass: 1'b0};
    tbl[2] = '{gray: 1'b1, mode: 2'd0, exp_err: 5'd0,  exp_fev: 4'h0, exp_fevalid: 1'b0, exp_pass: 1'b1};
    tbl[3] = '{gray: 1'b1, mode: 2'd1, exp_err: 5'd1,  exp_fev: 4'hA, exp_fevalid: 1'b1, exp_pass: 1'b0};
    tbl[4] = '{gray: 1'b0, mode: 2'd2, exp_err: 5'h10, exp_fev: 4'h0, exp_fevalid: 1'b1, exp_pass: 1'b0};
    tbl[5] = '{gray: 1'b1, mode: 2'd2, exp_err: 5'h10, exp_fev: 4'h0, exp_fevalid: 1'b1, exp_pass: 1'b0};

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    b_start = 1'b0;
    b_abort = 1'b0;

    #2;
    checkOutput("reset vec", a_vec, 0);
    checkOutput("reset busy", a_busy, 0);
    checkOutput("reset done", a_done, 0);
    checkOutput("reset pass", a_pass, 0);
    checkOutput("reset err_count", a_err, 0);
    checkOutput("reset first_err_valid", a_fevalid, 0);
    checkOutput("reset h1 vec_valid", b_vec_valid, 0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 6; i++) runSweepA(tbl[i], i);

    // Continuous Gray sweep against an always-wrong golden: wrap, saturate, ignored start, abort
    @(negedge clk); applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 2'd2);
    @(negedge clk); applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 2'd2);
    for (int k = 0; k < 200; k++) begin
      if (k == 61) checkOutput("cont gray last vec", a_vec, 4'h8);
      if (k == 64) checkOutput("cont err after pass1", a_err, 16);
      if (k == 65) begin
        checkOutput("cont gray wrap vec", a_vec, 4'h0);
        checkOutput("cont busy after wrap", a_busy, 1);
      end
      if (k == 100) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd2);
      if (k == 101) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
      if (k == 102) checkOutput("start in drive ignored", a_err, 25);
      @(negedge clk);
    end
    checkOutput("cont err saturated", a_err, 5'h1F);
    checkOutput("cont done low", a_done, 0);
    checkOutput("cont first_err_vec", a_fev, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd2);
    @(negedge clk); applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
    checkOutput("abort busy", a_busy, 0);
    checkOutput("abort vec_valid", a_vec_valid, 0);
    checkOutput("abort done", a_done, 0);
    checkOutput("abort err held", a_err, 5'h1F);
    checkOutput("abort first_err_valid held", a_fevalid, 1);

    // Continuous binary sweep wraps after F
    @(negedge clk); applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'd0);
    @(negedge clk); applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    for (int k = 0; k < 70; k++) begin
      if (k == 61) checkOutput("cont bin last vec", a_vec, 4'hF);
      if (k == 65) checkOutput("cont bin wrap vec", a_vec, 4'h0);
      if (k == 66) checkOutput("cont bin err", a_err, 0);
      @(negedge clk);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    @(negedge clk); applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    checkOutput("bin abort busy", a_busy, 0);

    // Asynchronous reset mid-dwell at vec 5
    @(negedge clk); applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd2);
    @(negedge clk); applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
    repeat (21) @(negedge clk);
    checkOutput("pre-reset vec", a_vec, 5);
    checkOutput("pre-reset err", a_err, 5);
    #2 rst = 1'b1;
    #1;
    checkOutput("async reset vec", a_vec, 0);
    checkOutput("async reset busy", a_busy, 0);
    checkOutput("async reset vec_valid", a_vec_valid, 0);
    checkOutput("async reset err", a_err, 0);
    checkOutput("async reset first_err_vec", a_fev, 0);
    checkOutput("async reset first_err_valid", a_fevalid, 0);
    @(negedge clk); rst = 1'b0;
    runSweepA(tbl[0], 6);

    // HOLD=1: sweep, then start+abort together in DONE, then a fresh sweep
    runSweepB(0);
    b_start = 1'b1;
    b_abort = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    b_abort = 1'b0;
    checkOutput("h1 start+abort done", b_done, 0);
    checkOutput("h1 start+abort busy", b_busy, 0);
    runSweepB(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
